// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width, default baud divisor, FSM encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_W  = 8;
  localparam int unsigned BAUD_DIV_DEF = 216;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data and registered flags that trail the pointers by one cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              ovf
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;

  // Acceptance uses the live count, so back-to-back writes can never overrun storage.
  assign push = wr_en && (count != (AW+1)'(DEPTH));
  assign pop  = rd_en && (count != '0);

  // dout always shows the head entry one cycle later, in step with the trailing flags.
  // Consumers must not pop again in the cycle right after a pop.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= din;
    dout <= mem[rd_ptr];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      level <= count;
      full  <= (count == (AW+1)'(DEPTH));
      empty <= (count == '0);
      if (wr_en && !push) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialized back-to-back on tx.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_DEF,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_dat,
  output logic                   full,
  output logic                   empty,
  output logic [FIFO_AW:0]       level,
  output logic                   ovf,
  output logic                   busy,
  output logic                   tx_done,
  output logic                   tx
);

  tx_state_e              state;
  logic [CNT_WIDTH-1:0]   baud_cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] sh;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   pop;
  logic                   bit_end;

  assign pop     = (state == IDLE) && !empty;
  assign bit_end = (baud_cnt == CNT_WIDTH'(BAUD_DIV - 1));

  sync_fifo #(
    .DATA_W (UART_DATA_W),
    .AW     (FIFO_AW)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (wr_en),
    .din       (wr_dat),
    .rd_en     (pop),
    .dout      (fifo_dout),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .ovf       (ovf)
  );

  // Serializer: tx, busy and tx_done are registered alongside the state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (!empty) begin
            sh       <= fifo_dout;
            baud_cnt <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= sh[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_WIDTH'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= sh[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_WIDTH'(1);
          end
        end
        STOP: begin
          // Raised one count early so the pulse lands in the final stop-bit cycle.
          if (baud_cnt == CNT_WIDTH'(BAUD_DIV - 2)) tx_done <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a fast-baud instance for framing/FIFO cases, a default-baud instance for timing.
module tb_uart_tx_fifo;

  localparam int BD = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic       wr_en1 = 1'b0, wr_en2 = 1'b0;
  logic [7:0] wr_dat1 = '0, wr_dat2 = '0;
  logic       full1, empty1, ovf1, busy1, tx_done1, tx1;
  logic       full2, empty2, ovf2, busy2, tx_done2, tx2;
  logic [4:0] level1, level2;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  uart_tx_fifo #(.BAUD_DIV(BD), .CNT_WIDTH(8), .FIFO_AW(4)) u_d1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en1), .wr_dat(wr_dat1),
    .full(full1), .empty(empty1), .level(level1), .ovf(ovf1),
    .busy(busy1), .tx_done(tx_done1), .tx(tx1));

  uart_tx_fifo u_d2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en2), .wr_dat(wr_dat2),
    .full(full2), .empty(empty2), .level(level2), .ovf(ovf2),
    .busy(busy2), .tx_done(tx_done2), .tx(tx2));

  typedef struct {
    int         at;
    logic       tx;
    logic       busy;
    logic       done;
    logic       empty;
    logic [4:0] level;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic write1(input logic [7:0] d);
    wr_dat1 = d;
    wr_en1  = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    wr_en1  = 1'b0;
  endtask

  // Bench 8N1 receiver on tx1: samples mid-bit, returns the cycle the start bit was first seen.
  task automatic rx_byte(output logic [7:0] b, output int t0, output logic ok);
    ok = 1'b0;
    b  = '0;
    t0 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (tx1 === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    t0 = cyc;
    repeat (BD / 2) @(negedge sys_clk);
    if (tx1 !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge sys_clk);
      b[i] = tx1;
    end
    repeat (BD) @(negedge sys_clk);
    if (tx1 !== 1'b1) ok = 1'b0;
  endtask

  initial begin : main
    logic [7:0] b;
    logic       ok;
    int         t, tprev, idx, maxlvl, lows, ntr, t_fall, t_done, t_idle;
    logic       fullseen, seen, prev;
    int         tr [12];

    // Checkpoints of the A5 frame, offsets in cycles after the write edge.
    vt[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
    vt[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
    vt[2]  = '{2,  1'b0, 1'b1, 1'b0, 1'b0, 5'd1};
    vt[3]  = '{3,  1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[4]  = '{5,  1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[5]  = '{6,  1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[6]  = '{9,  1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[7]  = '{10, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[8]  = '{14, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[9]  = '{18, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[10] = '{22, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[11] = '{26, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[12] = '{30, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[13] = '{33, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[14] = '{34, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[15] = '{38, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[16] = '{40, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
    vt[17] = '{41, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0};
    vt[18] = '{42, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
    vt[19] = '{43, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0};

    // Reset state
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_tx", tx1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_done", tx_done1, 0);
    chk("rst_empty", empty1, 1);
    chk("rst_full", full1, 0);
    chk("rst_level", level1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_tx2", tx2, 1);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single byte A5
    write1(8'hA5);
    idx = 0;
    for (int m = 0; m <= 43; m++) begin
      if (idx < 20 && vt[idx].at == m) begin
        chk($sformatf("single_tx_m%0d", m), tx1, vt[idx].tx);
        chk($sformatf("single_busy_m%0d", m), busy1, vt[idx].busy);
        chk($sformatf("single_done_m%0d", m), tx_done1, vt[idx].done);
        chk($sformatf("single_empty_m%0d", m), empty1, vt[idx].empty);
        chk($sformatf("single_level_m%0d", m), level1, vt[idx].level);
        idx++;
      end
      @(negedge sys_clk);
    end

    // Burst of 16 bytes
    do_reset();
    maxlvl = 0;
    fullseen = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          wr_dat1 = 8'(i);
          wr_en1  = 1'b1;
          @(posedge sys_clk);
          @(negedge sys_clk);
        end
        wr_en1 = 1'b0;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge sys_clk);
          if (int'(level1) > maxlvl) maxlvl = int'(level1);
          if (full1) fullseen = 1'b1;
        end
      end
      begin
        tprev = 0;
        for (int k = 0; k < 16; k++) begin
          rx_byte(b, t, ok);
          chk($sformatf("burst_ok_%0d", k), ok, 1);
          chk($sformatf("burst_dat_%0d", k), b, k);
          if (k > 0) chk($sformatf("burst_gap_%0d", k), t - tprev, 10 * BD + 1);
          tprev = t;
        end
      end
    join
    chk("burst_maxlevel", maxlvl, 15);
    chk("burst_fullseen", fullseen, 0);

    // Overflow: 17 writes while a frame is running
    do_reset();
    write1(8'hC3);
    fork
      begin
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < 17; i++) begin
          wr_dat1 = 8'(8'h10 + i);
          wr_en1  = 1'b1;
          @(posedge sys_clk);
          @(negedge sys_clk);
          if (i == 15) chk("ovf_before17", ovf1, 0);
        end
        wr_en1 = 1'b0;
        chk("ovf_set", ovf1, 1);
        chk("ovf_full", full1, 1);
        chk("ovf_level", level1, 16);
      end
      begin
        for (int k = 0; k < 17; k++) begin
          rx_byte(b, t, ok);
          chk($sformatf("ovf_rx_ok_%0d", k), ok, 1);
          chk($sformatf("ovf_rx_dat_%0d", k), b, (k == 0) ? 8'hC3 : 8'(8'h10 + k - 1));
        end
      end
    join
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (tx1 !== 1'b1) lows++;
    end
    chk("ovf_no17th", lows, 0);
    chk("ovf_drained", empty1, 1);
    chk("ovf_sticky", ovf1, 1);

    // Write coinciding with the IDLE pop while full
    do_reset();
    write1(8'h81);
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 16; i++) begin
      wr_dat1 = 8'(8'h40 + i);
      wr_en1  = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    wr_en1 = 1'b0;
    @(negedge sys_clk);
    chk("pp_full", full1, 1);
    chk("pp_level16", level1, 16);
    chk("pp_ovf0", ovf1, 0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx_done1 === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    chk("pp_done_seen", seen, 1);
    @(posedge sys_clk);
    @(negedge sys_clk);
    wr_dat1 = 8'hEE;
    wr_en1  = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    wr_en1 = 1'b0;
    chk("pp_ovf1", ovf1, 1);
    chk("pp_popped_tx", tx1, 0);
    chk("pp_busy", busy1, 1);
    @(negedge sys_clk);
    chk("pp_level15", level1, 15);
    chk("pp_full0", full1, 0);

    // Reset during DATA bit 3
    do_reset();
    write1(8'h3C);
    repeat (19) @(negedge sys_clk);
    chk("mid_busy_pre", busy1, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_tx", tx1, 1);
    chk("mid_busy", busy1, 0);
    chk("mid_level", level1, 0);
    chk("mid_empty", empty1, 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    lows = 0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (tx1 !== 1'b1) lows++;
      if (busy1 !== 1'b0) seen = 1'b1;
    end
    chk("mid_no_residual", lows, 0);
    chk("mid_no_busy", seen, 0);

    // Default-baud instance: 55 toggles the line every bit
    wr_dat2 = 8'h55;
    wr_en2  = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    wr_en2 = 1'b0;
    ntr = 0;
    t_done = -1;
    t_idle = -1;
    prev = tx2;
    for (int i = 0; i < 2300; i++) begin
      @(negedge sys_clk);
      if (tx2 !== prev) begin
        if (ntr < 12) tr[ntr] = cyc;
        ntr++;
      end
      prev = tx2;
      if (tx_done2 === 1'b1 && t_done < 0) t_done = cyc;
      if (ntr > 0 && busy2 === 1'b0 && t_idle < 0) t_idle = cyc;
    end
    chk("def_transitions", ntr, 10);
    t_fall = tr[0];
    for (int i = 1; i < 10; i++) chk($sformatf("def_bit_period_%0d", i), tr[i] - tr[i-1], 216);
    chk("def_done_at", t_done - t_fall, 2159);
    chk("def_frame_len", t_idle - t_fall, 2160);
    chk("def_ovf", ovf2, 0);
    chk("def_empty", empty2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
